// File: rtl/ram_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// ram_burst_ctrl_if
// Bundles every non-clock/reset signal of the burst controller:
//   cmd_*      : burst command (start address, beats-1, direction), valid/ready
//   wd_*       : write-data beat stream, valid/ready
//   rd_*       : read-data beat stream out of the response FIFO, valid/ready
//   ram_*      : single-port RAM port (we/addr/wdata out, rdata in)
//   busy       : controller has outstanding work
// modport slave  : the controller side
// modport master : the environment side (command source, data source/sink, RAM)
// -----------------------------------------------------------------------------
interface ram_burst_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wd_valid, wd_data,
        input  rd_ready,
        input  ram_rdata,
        output cmd_ready, wd_ready,
        output rd_valid, rd_data, rd_last,
        output ram_we, ram_addr, ram_wdata,
        output busy
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wd_valid, wd_data,
        output rd_ready,
        output ram_rdata,
        input  cmd_ready, wd_ready,
        input  rd_valid, rd_data, rd_last,
        input  ram_we, ram_addr, ram_wdata,
        input  busy
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// ram_burst_ctrl
// Burst-command front end for a single-port RAM with 1-cycle read latency.
// One command at a time is accepted in IDLE; a write burst moves beats from
// the wd stream straight onto the RAM port, a read burst issues RAM reads and
// returns the data through a small response FIFO on the rd stream.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rstn : asynchronous active-low reset (aborts any burst, flushes the FIFO)
//   bus  : ram_burst_ctrl_if.slave (command, write/read streams, RAM port, busy)
// -----------------------------------------------------------------------------
module ram_burst_ctrl #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    ram_burst_ctrl_if.slave   bus
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(RSP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              pending_q, pending_d;
    logic              pending_last_q, pending_last_d;

    logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];
    logic              fifo_last_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;

    logic              cmd_accept_s;
    logic              wr_beat_s;
    logic              issue_s;
    logic              beat_s;
    logic              last_beat_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_empty_s;
    logic [OCC_W-1:0]  occupancy_s;

    // Handshake and credit decode shared by the next-state and output logic
    always_comb begin
        fifo_empty_s = (fifo_count_q == {CNT_W{1'b0}});
        // Credits count both buffered beats and the read still in the RAM
        // pipe; a pop in the same cycle is deliberately not credited.
        occupancy_s  = {1'b0, fifo_count_q} + {{(OCC_W-1){1'b0}}, pending_q};
        cmd_accept_s = (state_q == ST_IDLE) && bus.cmd_valid;
        wr_beat_s    = (state_q == ST_WRITE) && bus.wd_valid;
        issue_s      = (state_q == ST_READ) && (occupancy_s < OCC_FULL);
        beat_s       = wr_beat_s || issue_s;
        last_beat_s  = (remaining_q == {LEN_W{1'b0}});
        // The RAM returns data one cycle after the issue, whatever the FSM
        // is doing now, so capture is driven purely by pending_q.
        push_s       = pending_q;
        pop_s        = bus.rd_ready && !fifo_empty_s;
    end

    // Next-state logic for the FSM and burst datapath
    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        remaining_d    = remaining_q;
        pending_d      = issue_s;
        pending_last_d = pending_last_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept_s) begin
                    cur_addr_d  = bus.cmd_addr;
                    remaining_d = bus.cmd_len;
                    state_d     = bus.cmd_write ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE, ST_READ: begin
                if (beat_s) begin
                    // Address wraps naturally at 2**ADDR_W
                    cur_addr_d = cur_addr_q + ADDR_ONE;
                    if (last_beat_s) begin
                        remaining_d = remaining_q;
                        state_d     = ST_IDLE;
                    end else begin
                        remaining_d = remaining_q - LEN_ONE;
                        state_d     = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (issue_s) begin
            pending_last_d = last_beat_s;
        end else begin
            pending_last_d = pending_last_q;
        end
    end

    // Response FIFO pointer and occupancy next-state
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State and burst/FIFO control registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            cur_addr_q     <= {ADDR_W{1'b0}};
            remaining_q    <= {LEN_W{1'b0}};
            pending_q      <= 1'b0;
            pending_last_q <= 1'b0;
            wr_ptr_q       <= {PTR_W{1'b0}};
            rd_ptr_q       <= {PTR_W{1'b0}};
            fifo_count_q   <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            remaining_q    <= remaining_d;
            pending_q      <= pending_d;
            pending_last_q <= pending_last_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_count_q   <= fifo_count_d;
        end
    end

    // Response FIFO storage: {ram_rdata, last} captured in issue order
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_data_q[i] <= {DATA_W{1'b0}};
                fifo_last_q[i] <= 1'b0;
            end
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= bus.ram_rdata;
            fifo_last_q[wr_ptr_q] <= pending_last_q;
        end
    end

    // Output decode: handshakes, RAM port, read stream and busy
    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.wd_ready  = (state_q == ST_WRITE);
        bus.ram_we    = wr_beat_s;
        bus.ram_addr  = cur_addr_q;
        if (state_q == ST_WRITE) begin
            bus.ram_wdata = bus.wd_data;
        end else begin
            bus.ram_wdata = {DATA_W{1'b0}};
        end
        bus.rd_valid = !fifo_empty_s;
        // Stale entries stay hidden once the FIFO drains
        if (fifo_empty_s) begin
            bus.rd_data = {DATA_W{1'b0}};
            bus.rd_last = 1'b0;
        end else begin
            bus.rd_data = fifo_data_q[rd_ptr_q];
            bus.rd_last = fifo_last_q[rd_ptr_q];
        end
        bus.busy = (state_q != ST_IDLE) || pending_q || !fifo_empty_s;
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Burst-command front-end that sits directly upstream of the 16 KiB single-port RAM and drives its we/addr/wdata port.
- Accepts one command at a time (start address, beat count, direction).
- Write beats arrive on a valid/ready write-data stream and are written to the RAM.
- Read beats are issued to the RAM, and the data is returned on a valid/ready read-data stream through a credit-limited response FIFO, so downstream backpressure never loses data.

Parameters:
ADDR_W, 14, RAM address width; addresses wrap modulo 2**ADDR_W
DATA_W, 8, RAM data width
LEN_W, 8, command length field width; beats = cmd_len+1 (1..2**LEN_W)
RSP_DEPTH, 4, read response FIFO depth; power of two, >=2

Ports:
clk  in  1  clock; all state changes on rising edge
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  burst start address
cmd_len  in  LEN_W  beats minus one
wd_valid  in  1  write beat valid
wd_ready  out  1  write beat accepted when wd_valid&&wd_ready
wd_data  in  DATA_W  write beat data
rd_valid  out  1  read beat available (FIFO non-empty)
rd_ready  in  1  consumer pops the beat when rd_valid&&rd_ready
rd_data  out  DATA_W  read beat data (FIFO head)
rd_last  out  1  head beat is final beat of its burst
ram_we  out  1  to RAM we
ram_addr  out  ADDR_W  to RAM addr
ram_wdata  out  DATA_W  to RAM wdata
ram_rdata  in  DATA_W  from RAM rdata; valid the cycle after a read issue
busy  out  1  state!=IDLE or read pending or FIFO non-empty

Behaviour:
- States: IDLE, WRITE, READ. Registers: cur_addr, remaining (beats-1), pending (read issued last cycle), pending_last, FIFO (data+last, count).
- Reset (async, rstn=0): state=IDLE, cur_addr=0, remaining=0, pending=0, FIFO flushed. Outputs: cmd_ready=1, wd_ready=0, rd_valid=0, rd_data=0, rd_last=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0. Reset mid-burst aborts the burst and drops in-flight and buffered reads.
- cmd_ready = (state==IDLE). This is independent of FIFO occupancy.
- On command accept: cur_addr<=cmd_addr, remaining<=cmd_len, state<=WRITE if cmd_write, else READ.
- WRITE:
  - wd_ready=1.
  - ram_we = wd_valid; ram_addr = cur_addr; ram_wdata = wd_data (combinational).
  - Per accepted beat: cur_addr<=cur_addr+1 mod 2**ADDR_W; remaining<=remaining-1.
  - On the beat with remaining==0, go to IDLE.
  - A cycle without wd_valid writes nothing and advances nothing.
- READ:
  - A read is issued when fifo_count+pending < RSP_DEPTH. This check is conservative and ignores a pop in the same cycle.
  - On issue: ram_we=0, ram_addr=cur_addr, pending<=1, pending_last<=(remaining==0).
  - Then advance cur_addr and remaining exactly as for writes. On the last issue, go to IDLE.
  - No issue this cycle means pending<=0.
- IDLE and non-issuing cycles: ram_we=0, ram_addr=cur_addr.
- Capture: when pending==1, push {ram_rdata, pending_last} into the FIFO that cycle. This gives 1-cycle RAM latency, and the first beat reaches rd_valid 2 cycles after issue.
- Capture happens even if state has already returned to IDLE or a new WRITE has started. A write in the capture cycle does not corrupt it, because the RAM updates rdata only on non-write edges.
- FIFO:
  - A push and a pop in the same cycle keep the count unchanged.
  - The credit rule guarantees no push into a full FIFO. An overflow is a design error and must be flagged by a bench assertion.
  - Data order equals issue order.
- Address wrap: 0x3FFF+1 → 0x0000. Bursts may cross the wrap point.
- Sustained throughput: 1 beat/cycle for writes with wd_valid held high. Reads run at 1 beat/cycle with rd_ready held high.

Test Plan:
1. Write burst: cmd_write=1, addr=0x0010, len=3, wd_data A0,A1,A2,A3 back-to-back → ram_we high 4 cycles at 0x0010..0x0013. Then read burst with the same addr/len → rd_data A0..A3, rd_last only on A3.
2. Wrap: write addr=0x3FFE, len=3, data 11,22,33,44 → ram_addr 0x3FFE,0x3FFF,0x0000,0x0001. Read back returns 11,22,33,44.
3. Backpressure: read addr=0, len=15, rd_ready=0 → exactly 4 issues, rd_valid=1 with the FIFO holding 4 beats. Then rd_ready=1 → all 16 beats delivered in address order, none lost or duplicated.
4. Write gaps: len=3 with wd_valid pattern 1,0,1,0,1,1 → ram_we asserted only on the 4 valid cycles. Addresses are contiguous, and the block returns to IDLE after the 4th beat.
5. Command while busy: assert cmd_valid during a write burst → cmd_ready=0. The held command is accepted on the first IDLE cycle, and a read accepted while the FIFO still drains returns correct data.
6. Reset mid-read: assert rstn=0 two cycles into a len=7 read → rd_valid=0, busy=0, ram_we=0 immediately. After release, cmd_ready=1 and a new burst completes normally.
